core_scheduler: RTL and testbench

- Per-core control FSM that sequences the SIMT datapath through fetch, decode, request, wait, execute and update phases.
- Broadcasts core_state to every per-thread PC, ALU and LSU unit.
- Owns the single shared current_pc. On each UPDATE it commits the converged next_pc from the lowest-index enabled thread.
- Raises done when a RET instruction retires.

---
 rtl/gpu_core_pkg.sv | 24 ++
 rtl/core_scheduler_if.sv | 32 +++
 rtl/lane_select.sv | 23 ++
 rtl/core_scheduler.sv | 136 +++++++++++++
 tb/tb_core_scheduler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_core_pkg.sv
// Shared core-level definitions for the SIMT core.
// core_state_t is broadcast to every per-thread PC/ALU/LSU unit, and those
// units decode these exact encodings, so the values must not change.
// sel_w() sizes lane-index fields and never returns 0, so THREADS=1 still works.
package gpu_core_pkg;

  localparam int CORE_STATE_W = 3;

  typedef enum logic [CORE_STATE_W-1:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// Scheduler <-> SIMT datapath bundle.
//   core_state  : phase broadcast to the per-thread units
//   current_pc  : shared PC presented to the fetcher and the PC units
//   fetch_valid : fetcher holds the instruction for current_pc
//   dec_ret     : decoded instruction is RET (valid from DECODE onward)
//   lsu_busy    : per-thread LSU outstanding request
//   next_pc     : packed per-thread next PC, lane i at [i*PC_BITS +: PC_BITS]
// Modports: sched (scheduler side), datapath (units side).
interface core_scheduler_if #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) ();
  import gpu_core_pkg::*;

  core_state_t                  core_state;
  logic [PC_BITS-1:0]           current_pc;
  logic                         fetch_valid;
  logic                         dec_ret;
  logic [THREADS-1:0]           lsu_busy;
  logic [THREADS*PC_BITS-1:0]   next_pc;

  modport sched (
    output core_state, current_pc,
    input  fetch_valid, dec_ret, lsu_busy, next_pc
  );

  modport datapath (
    input  core_state, current_pc,
    output fetch_valid, dec_ret, lsu_busy, next_pc
  );

endinterface

// File: rtl/lane_select.sv
// Lowest-set-bit priority encoder over the active lane mask.
//   mask : enabled lanes
//   lane : index of the lowest set bit (0 when mask is empty; the scheduler
//          never launches with an empty mask, so that case is unused)
module lane_select
  import gpu_core_pkg::*;
#(
  parameter int THREADS = 4,
  localparam int SEL_W  = sel_w(THREADS)
) (
  input  logic [THREADS-1:0] mask,
  output logic [SEL_W-1:0]   lane
);

  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    lane = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (mask[i]) lane = SEL_W'(i);
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM for the SIMT datapath.
// Sequences IDLE -> FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE,
// looping back to FETCH until a RET retires in UPDATE, then parks in DONE
// until start drops. Owns the shared PC and commits the next_pc of the
// lowest-index enabled lane on each UPDATE.
// Ports:
//   clk, reset (async, active low)
//   start       : level launch request, honoured in IDLE (and releases DONE)
//   thread_mask : enabled lanes, latched at launch
//   dp          : datapath bundle (core_scheduler_if.sched)
//   active_mask : latched thread_mask
//   done        : high while in DONE
//   diverged    : only with CORE_SCHED_DIVERGE_CHECK_EN; sticky flag set when
//                 enabled lanes disagree on next_pc at a non-RET UPDATE,
//                 cleared by reset or a new launch
// All outputs are registered.
module core_scheduler
  import gpu_core_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [THREADS-1:0] thread_mask,
  core_scheduler_if.sched    dp,
  output logic [THREADS-1:0] active_mask,
  output logic               done
`ifdef CORE_SCHED_DIVERGE_CHECK_EN
  ,
  output logic               diverged
`endif
);

  localparam int SEL_W = sel_w(THREADS);

  core_state_t          state_q, state_d;
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic [THREADS-1:0]   mask_q, mask_d;
  logic                 done_q;
  logic                 launch;
  logic [SEL_W-1:0]     sel_lane;
  logic [PC_BITS-1:0]   sel_pc;
  logic [PC_BITS-1:0]   lane_pc [THREADS];

  for (genvar g = 0; g < THREADS; g++) begin : g_lane_pc
    assign lane_pc[g] = dp.next_pc[g*PC_BITS +: PC_BITS];
  end

  lane_select #(.THREADS(THREADS)) u_lane_select (
    .mask (mask_q),
    .lane (sel_lane)
  );

  assign sel_pc = lane_pc[sel_lane];
  assign launch = start && (thread_mask != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      // done tracks the next state so it drops on the same edge IDLE is entered.
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          mask_d  = thread_mask;
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH:   if (dp.fetch_valid) state_d = DECODE;
      DECODE:  state_d = REQUEST;
      REQUEST: state_d = WAIT;
      // Disabled lanes may carry stale busy bits; only enabled lanes gate.
      WAIT:    if ((dp.lsu_busy & mask_q) == '0) state_d = EXECUTE;
      EXECUTE: state_d = UPDATE;
      UPDATE: begin
        if (dp.dec_ret) begin
          state_d = DONE;
        end else begin
          pc_d    = sel_pc;
          state_d = FETCH;
        end
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dp.core_state = state_q;
  assign dp.current_pc = pc_q;
  assign active_mask   = mask_q;
  assign done          = done_q;

`ifdef CORE_SCHED_DIVERGE_CHECK_EN
  logic div_q, div_d, lane_mismatch;

  always_comb begin
    lane_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (mask_q[i] && (lane_pc[i] != sel_pc)) lane_mismatch = 1'b1;
    end
  end

  always_comb begin
    div_d = div_q;
    if (state_q == IDLE && launch)
      div_d = 1'b0;
    else if (state_q == UPDATE && !dp.dec_ret && lane_mismatch)
      div_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= 1'b0;
    else        div_q <= div_d;
  end

  assign diverged = div_q;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: directed vector table, hand-written corner
// sequences, and randomized blocks checked against an instruction-level model.
module tb_core_scheduler;
  import gpu_core_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] thread_mask;
  logic [3:0] active_mask;
  logic       done;
`ifdef CORE_SCHED_DIVERGE_CHECK_EN
  logic       diverged;
`endif

  int checks = 0;
  int failures = 0;
  int wait_seen = 0;

  // model state
  logic [7:0] m_pc;
  logic [3:0] m_mask;
  logic       m_div;

  core_scheduler_if #(.THREADS(4), .PC_BITS(8)) dp ();

  core_scheduler #(.THREADS(4), .PC_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .thread_mask (thread_mask),
    .dp          (dp),
    .active_mask (active_mask),
    .done        (done)
`ifdef CORE_SCHED_DIVERGE_CHECK_EN
    ,
    .diverged    (diverged)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  // One cycle inside a block: check the phase the model expects, then drive.
  // start/thread_mask are scrambled to show they are ignored mid-block.
  task automatic cyc(input core_state_t exp, input logic fv, input logic [3:0] busy,
                     input logic ret);
    chk("state", 32'(dp.core_state), 32'(exp));
    chk("pc", 32'(dp.current_pc), 32'(m_pc));
    chk("done", 32'(done), 32'(0));
    chk("mask", 32'(active_mask), 32'(m_mask));
`ifdef CORE_SCHED_DIVERGE_CHECK_EN
    chk("div", 32'(diverged), 32'(m_div));
`endif
    if (dp.core_state == WAIT) wait_seen++;
    dp.fetch_valid = fv;
    dp.lsu_busy    = busy;
    dp.dec_ret     = ret;
    start          = 1'($urandom_range(0, 1));
    thread_mask    = 4'($urandom);
    @(negedge clk);
  endtask

  // One instruction: fw fetch stall cycles, bw busy WAIT cycles (busy_pat
  // must hit an enabled lane), idle_busy is the last WAIT cycle's pattern
  // restricted to disabled lanes.
  task automatic instr(input int fw, input int bw, input logic [3:0] busy_pat,
                       input logic [3:0] idle_busy, input logic ret, input logic [31:0] npc);
    int sel;
    logic [7:0] npc_l;
    dp.next_pc = $urandom;
    for (int i = 0; i < fw; i++) cyc(FETCH, 1'b0, 4'($urandom), 1'($urandom));
    cyc(FETCH, 1'b1, 4'($urandom), 1'($urandom));
    cyc(DECODE, 1'($urandom), 4'($urandom), 1'($urandom));
    cyc(REQUEST, 1'($urandom), 4'($urandom), 1'($urandom));
    for (int i = 0; i < bw; i++)
      cyc(WAIT, 1'($urandom), busy_pat | (4'($urandom) & ~m_mask), 1'($urandom));
    cyc(WAIT, 1'($urandom), idle_busy & ~m_mask, 1'($urandom));
    cyc(EXECUTE, 1'($urandom), 4'($urandom), 1'($urandom));
    dp.next_pc = npc;
    cyc(UPDATE, 1'($urandom), 4'($urandom), ret);
    if (!ret) begin
      sel = lowest(m_mask);
      npc_l = npc[sel*8 +: 8];
      for (int i = 0; i < 4; i++)
        if (m_mask[i] && npc[i*8 +: 8] != npc_l) m_div = 1'b1;
      m_pc = npc_l;
    end
  endtask

  task automatic launch(input logic [3:0] mask);
    chk("launch_idle", 32'(dp.core_state), 32'(IDLE));
    start       = 1'b1;
    thread_mask = mask;
    @(negedge clk);
    m_mask = mask;
    m_pc   = 8'h00;
    m_div  = 1'b0;
  endtask

  task automatic finish_block(input int hold);
    chk("done_state", 32'(dp.core_state), 32'(DONE));
    chk("done_flag", 32'(done), 32'(1));
    chk("done_pc", 32'(dp.current_pc), 32'(m_pc));
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      thread_mask = 4'($urandom);
      @(negedge clk);
      chk("done_hold", 32'(dp.core_state), 32'(DONE));
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_exit", 32'(dp.core_state), 32'(IDLE));
    chk("done_drop", 32'(done), 32'(0));
  endtask

  typedef struct {
    logic        s;
    logic [3:0]  m;
    logic        r;
    logic [31:0] npc;
    core_state_t st;
    logic [7:0]  pc;
    logic        dn;
    logic [3:0]  am;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [3:0] m, input logic r,
                              input logic [31:0] npc, input core_state_t st,
                              input logic [7:0] pc, input logic dn, input logic [3:0] am);
    vec_t v;
    v.s = s; v.m = m; v.r = r; v.npc = npc; v.st = st; v.pc = pc; v.dn = dn; v.am = am;
    return v;
  endfunction

  vec_t tbl [28];

  initial begin
    localparam logic [31:0] I1 = 32'h2B2A_1177;  // lane2=2A, lane0=77 (masked off)
    localparam logic [31:0] I2 = 32'h00FF_0000;  // lane2=FF
    localparam logic [31:0] I3 = 32'h0000_7777;  // lane2=FF+1 wrapped to 00
    localparam logic [31:0] I4 = 32'h0055_0000;  // RET: pc must not take 55

    // Launch with empty mask, then mask 1100; start/mask scrambled mid-block.
    tbl[0]  = mk(1, 4'b0000, 0, I1, IDLE,    8'h00, 0, 4'b0000);
    tbl[1]  = mk(1, 4'b1100, 0, I1, FETCH,   8'h00, 0, 4'b1100);
    tbl[2]  = mk(1, 4'b1100, 0, I1, DECODE,  8'h00, 0, 4'b1100);
    tbl[3]  = mk(0, 4'b0001, 0, I1, REQUEST, 8'h00, 0, 4'b1100);
    tbl[4]  = mk(1, 4'b0001, 0, I1, WAIT,    8'h00, 0, 4'b1100);
    tbl[5]  = mk(0, 4'b0001, 0, I1, EXECUTE, 8'h00, 0, 4'b1100);
    tbl[6]  = mk(1, 4'b0001, 0, I1, UPDATE,  8'h00, 0, 4'b1100);
    tbl[7]  = mk(0, 4'b0001, 0, I1, FETCH,   8'h2A, 0, 4'b1100);
    tbl[8]  = mk(1, 4'b1111, 0, I2, DECODE,  8'h2A, 0, 4'b1100);
    tbl[9]  = mk(0, 4'b1111, 1, I2, REQUEST, 8'h2A, 0, 4'b1100);
    tbl[10] = mk(1, 4'b1111, 0, I2, WAIT,    8'h2A, 0, 4'b1100);
    tbl[11] = mk(0, 4'b1111, 0, I2, EXECUTE, 8'h2A, 0, 4'b1100);
    tbl[12] = mk(1, 4'b1111, 0, I2, UPDATE,  8'h2A, 0, 4'b1100);
    tbl[13] = mk(0, 4'b1111, 0, I2, FETCH,   8'hFF, 0, 4'b1100);
    tbl[14] = mk(1, 4'b0010, 0, I3, DECODE,  8'hFF, 0, 4'b1100);
    tbl[15] = mk(0, 4'b0010, 0, I3, REQUEST, 8'hFF, 0, 4'b1100);
    tbl[16] = mk(1, 4'b0010, 0, I3, WAIT,    8'hFF, 0, 4'b1100);
    tbl[17] = mk(0, 4'b0010, 0, I3, EXECUTE, 8'hFF, 0, 4'b1100);
    tbl[18] = mk(1, 4'b0010, 0, I3, UPDATE,  8'hFF, 0, 4'b1100);
    tbl[19] = mk(0, 4'b0010, 0, I3, FETCH,   8'h00, 0, 4'b1100);
    tbl[20] = mk(1, 4'b0001, 0, I4, DECODE,  8'h00, 0, 4'b1100);
    tbl[21] = mk(1, 4'b0001, 0, I4, REQUEST, 8'h00, 0, 4'b1100);
    tbl[22] = mk(1, 4'b0001, 0, I4, WAIT,    8'h00, 0, 4'b1100);
    tbl[23] = mk(1, 4'b0001, 0, I4, EXECUTE, 8'h00, 0, 4'b1100);
    tbl[24] = mk(1, 4'b0001, 0, I4, UPDATE,  8'h00, 0, 4'b1100);
    tbl[25] = mk(1, 4'b0001, 1, I4, DONE,    8'h00, 1, 4'b1100);
    tbl[26] = mk(1, 4'b0001, 0, I4, DONE,    8'h00, 1, 4'b1100);
    tbl[27] = mk(0, 4'b0001, 0, I4, IDLE,    8'h00, 0, 4'b1100);

    reset = 1'b0; start = 1'b0; thread_mask = '0;
    dp.fetch_valid = 1'b0; dp.dec_ret = 1'b0; dp.lsu_busy = '0; dp.next_pc = '0;
    m_pc = '0; m_mask = '0; m_div = 1'b0;
    #2;
    chk("rst_state", 32'(dp.core_state), 32'(IDLE));
    chk("rst_pc", 32'(dp.current_pc), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_mask", 32'(active_mask), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    // Directed table: fetch_valid=1, no LSU traffic, one edge per entry.
    dp.fetch_valid = 1'b1;
    dp.lsu_busy = '0;
    foreach (tbl[k]) begin
      start = tbl[k].s; thread_mask = tbl[k].m;
      dp.dec_ret = tbl[k].r; dp.next_pc = tbl[k].npc;
      @(negedge clk);
      chk($sformatf("tbl%0d_state", k), 32'(dp.core_state), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_pc", k), 32'(dp.current_pc), 32'(tbl[k].pc));
      chk($sformatf("tbl%0d_done", k), 32'(done), 32'(tbl[k].dn));
      chk($sformatf("tbl%0d_mask", k), 32'(active_mask), 32'(tbl[k].am));
    end

    // Memory stall: lane 2 busy for 5 WAIT cycles -> 6 WAIT cycles.
    launch(4'b1111);
    wait_seen = 0;
    instr(0, 5, 4'b0100, 4'b0000, 1'b0, {4{8'h10}});
    chk("wait_stall", 32'(wait_seen), 32'(6));
    instr(1, 0, 4'b0000, 4'b0000, 1'b1, {4{8'h33}});
    finish_block(1);

    // Busy only on a masked-off lane -> single WAIT cycle.
    launch(4'b0011);
    wait_seen = 0;
    instr(0, 0, 4'b0000, 4'b1000, 1'b1, {4{8'h44}});
    chk("wait_masked", 32'(wait_seen), 32'(1));
    finish_block(0);

    // Async reset mid-WAIT.
    launch(4'b1111);
    instr(0, 0, 4'b0000, 4'b0000, 1'b0, {4{8'h05}});
    cyc(FETCH, 1'b1, 4'b0000, 1'b0);
    cyc(DECODE, 1'b1, 4'b0000, 1'b0);
    cyc(REQUEST, 1'b1, 4'b1111, 1'b0);
    chk("pre_rst_state", 32'(dp.core_state), 32'(WAIT));
    chk("pre_rst_pc", 32'(dp.current_pc), 32'(8'h05));
    dp.lsu_busy = 4'b1111;
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(dp.core_state), 32'(IDLE));
    chk("arst_pc", 32'(dp.current_pc), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_mask", 32'(active_mask), 32'(0));
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    m_pc = '0; m_mask = '0; m_div = 1'b0;
    chk("arst_hold", 32'(dp.core_state), 32'(IDLE));
    launch(4'b1111);
    chk("relaunch", 32'(dp.core_state), 32'(FETCH));
    instr(0, 0, 4'b0000, 4'b0000, 1'b1, {4{8'h01}});
    finish_block(0);

`ifdef CORE_SCHED_DIVERGE_CHECK_EN
    launch(4'b0011);
    instr(0, 0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0905);
    chk("div_set", 32'(diverged), 32'(1));
    instr(0, 0, 4'b0000, 4'b0000, 1'b0, {4{8'h0A}});
    chk("div_sticky", 32'(diverged), 32'(1));
    instr(0, 0, 4'b0000, 4'b0000, 1'b1, {4{8'h0B}});
    finish_block(0);
    launch(4'b0011);
    chk("div_clear", 32'(diverged), 32'(0));
    instr(0, 0, 4'b0000, 4'b0000, 1'b1, {4{8'h0C}});
    finish_block(0);
`endif

    // Randomized blocks against the instruction-level model.
    for (int b = 0; b < 40; b++) begin
      logic [3:0] msk;
      int n;
      msk = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 5);
      launch(msk);
      for (int k = 0; k < n; k++) begin
        int fw, bw;
        logic [3:0] bp;
        logic [31:0] npc;
        logic [7:0] v;
        fw = $urandom_range(0, 2);
        bw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        bp = 4'($urandom) & msk;
        if (bp == 4'b0000) bp = msk;
        v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        npc = ($urandom_range(0, 1) == 0) ? {4{v}} : $urandom;
        instr(fw, bw, bp, 4'($urandom), (k == n - 1), npc);
      end
      finish_block($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
